mux_4x1: RTL and testbench
==========================

# mux_4x1

Registered, parameterizable 4-to-1 multiplexer used as a data-path selector stage. Four equal-width data inputs are chosen by a 2-bit select (`s1`,`s0`). The selected word is captured into an output register on qualified cycles, with a matching valid flag. An optional even-parity output can be compiled in.

## Interface
Parameters:
- `WIDTH`, default 1: width of each data input and of `y`; legal range 1–64.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `a`  input  WIDTH  data input 0, selected when s1s0=00.
- `b`  input  WIDTH  data input 1, selected when s1s0=01 (s0=1, s1=0).
- `c`  input  WIDTH  data input 2, selected when s1s0=10 (s0=0, s1=1).
- `d`  input  WIDTH  data input 3, selected when s1s0=11.
- `s0`  input  1  select LSB.
- `s1`  input  1  select MSB.
- `in_valid`  input  1  qualifies data and select for capture this cycle.
- `y`  output  WIDTH  registered selected data.
- `y_valid`  output  1  high for one cycle per captured word.
- `sel_q`  output  2  select value {s1,s0} that produced the current `y`.
- `y_par`  output  1  even parity of `y`; present only with `MUX_4X1_PARITY_EN`.

## Operation
- Selection is combinational: sel = {s1,s0}. 00→a, 01→b, 10→c, 11→d. There is no invalid code.
- Rising edge with `in_valid`=1:
  - `y` ← selected input.
  - `sel_q` ← {s1,s0}.
  - `y_valid` ← 1.
- Rising edge with `in_valid`=0:
  - `y` and `sel_q` hold their values.
  - `y_valid` ← 0.
- Unselected inputs have no effect on any output.
- No handshake back-pressure: every valid input is accepted; throughput is one word per cycle.
- X on `s0`/`s1` while `in_valid`=1 is illegal. The bench flags it with an assertion; RTL behaviour is unspecified.

## Timing
- Reset (`rst_n`=0, asynchronous, takes effect immediately without a clock edge):
  - `y`=0, `sel_q`=2'b00, `y_valid`=0, `y_par`=0.
- Reset release is synchronous-safe: the first capture occurs on the first rising edge with `rst_n`=1 and `in_valid`=1.
- Latency is one cycle. Inputs sampled at edge N appear on `y`/`y_valid` after edge N.
- Back-to-back `in_valid` cycles produce back-to-back updates, with `y_valid` held high continuously.
- Select and data changes between edges are not visible on outputs; there is no output glitching.
- Reset asserted mid-stream clears outputs at once. The word in flight is discarded, and `y_valid` is 0 on the first post-reset cycle.

## Configuration
- `MUX_4X1_PARITY_EN` defined:
  - Port `y_par` and its register exist.
  - On each capture, `y_par` ← XOR-reduction of the selected word, so that `y` plus `y_par` has even parity.
  - `y_par` holds with `y` and resets to 0.
- `MUX_4X1_PARITY_EN` not defined:
  - `y_par` port and logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 with inputs toggling → `y`=0, `y_valid`=0, `sel_q`=00. Deassert `rst_n` mid-cycle, then `in_valid`=1, a=1, s1s0=00 → `y`=1 after the next edge.
- Select sweep, WIDTH=1, `in_valid`=1 each cycle; each row is a,b,c,d, s0,s1 → y:
  - 1,0,0,0, s0=0,s1=0 → y=1
  - 0,1,1,1, s0=0,s1=0 → y=0
  - 0,1,0,0, s0=1,s1=0 → y=1
  - 1,0,1,1, s0=1,s1=0 → y=0
  - 0,0,1,0, s0=0,s1=1 → y=1
  - 1,1,1,0, s0=0,s1=1 → y=1
  - 0,0,0,1, s0=1,s1=1 → y=1
  - 1,1,1,0, s0=1,s1=1 → y=0
  - Check each one cycle later, with `sel_q` matching the select.
- Hold: capture b=1 via s1s0=01, then drop `in_valid` and flip all inputs and selects for 3 cycles → `y`=1 and `sel_q`=01 held, `y_valid`=0.
- Isolation: WIDTH=8, a=8'hA5, b=8'h3C, c=8'hFF, d=8'h00, s1s0=10 → `y`=8'hFF. Changing a, b and d alone leaves `y` unchanged.
- Mid-stream reset: 4 consecutive valid words, pulse `rst_n` low between edges 2 and 3 → outputs clear immediately, and `y_valid`=0 on the first post-reset cycle.
- Parity build: with `MUX_4X1_PARITY_EN`, WIDTH=8, capture 8'h07 → `y_par`=1; capture 8'h03 → `y_par`=0. Without the macro, the design elaborates with no `y_par` port.

Source files
------------

// File: rtl/mux_4x1.sv
// Registered 4-to-1 word selector with valid flag and captured select.
// Optional even-parity output compiled in with MUX_4X1_PARITY_EN.
`timescale 1ns/1ps

module mux_4x1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s0,
    input  logic             s1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    output logic [1:0]       sel_q
`ifdef MUX_4X1_PARITY_EN
    ,
    output logic             y_par
`endif
);

    localparam int unsigned SEL_W = 2;

    logic [SEL_W-1:0] sel_c;
    logic [WIDTH-1:0] mux_c;

    assign sel_c = {s1, s0};

    // Combinational word select; every code maps to an input.
    always_comb begin
        mux_c = a;
        case (sel_c)
            2'b00:   mux_c = a;
            2'b01:   mux_c = b;
            2'b10:   mux_c = c;
            default: mux_c = d;
        endcase
    end

    // Capture on qualified cycles; y and sel_q hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            sel_q   <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= in_valid;
            if (in_valid) begin
                y     <= mux_c;
                sel_q <= sel_c;
            end
        end
    end

`ifdef MUX_4X1_PARITY_EN
    // Parity bit makes {y, y_par} even; captured alongside y.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_par <= 1'b0;
        end else if (in_valid) begin
            y_par <= ^mux_c;
        end
    end
`endif

endmodule

// File: tb/tb_mux_4x1.sv
// Self-checking bench for mux_4x1: directed cases plus randomized traffic
// against an array-indexed reference model, on WIDTH=1 and WIDTH=8 instances.
`timescale 1ns/1ps

module tb_mux_4x1;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       s0, s1;
    logic       a1, b1, c1, d1;
    logic       y1, y1_valid;
    logic [1:0] sel1_q;
    logic [7:0] a8, b8, c8, d8;
    logic [7:0] y8;
    logic       y8_valid;
    logic [1:0] sel8_q;
`ifdef MUX_4X1_PARITY_EN
    logic       y1_par, y8_par;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic       m_y1;
    logic [7:0] m_y8;
    logic [1:0] m_sel;
    logic       m_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux_4x1 #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .a(a1), .b(b1), .c(c1), .d(d1),
        .s0(s0), .s1(s1), .in_valid(in_valid),
        .y(y1), .y_valid(y1_valid), .sel_q(sel1_q)
`ifdef MUX_4X1_PARITY_EN
        , .y_par(y1_par)
`endif
    );

    mux_4x1 #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .a(a8), .b(b8), .c(c8), .d(d8),
        .s0(s0), .s1(s1), .in_valid(in_valid),
        .y(y8), .y_valid(y8_valid), .sel_q(sel8_q)
`ifdef MUX_4X1_PARITY_EN
        , .y_par(y8_par)
`endif
    );

    // Unknown select on a qualified cycle is illegal stimulus.
    always @(posedge clk) begin
        if (rst_n === 1'b1 && in_valid === 1'b1)
            assert (!$isunknown({s1, s0}));
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_y1  = 1'b0;
        m_y8  = 8'h00;
        m_sel = 2'b00;
        m_v   = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".y1"},     64'(y1),       64'(m_y1));
        check({ph, ".y8"},     64'(y8),       64'(m_y8));
        check({ph, ".sel1"},   64'(sel1_q),   64'(m_sel));
        check({ph, ".sel8"},   64'(sel8_q),   64'(m_sel));
        check({ph, ".vld1"},   64'(y1_valid), 64'(m_v));
        check({ph, ".vld8"},   64'(y8_valid), 64'(m_v));
`ifdef MUX_4X1_PARITY_EN
        check({ph, ".par1"},   64'(y1_par),   64'(m_y1));
        check({ph, ".par8"},   64'(y8_par),   64'($countones(m_y8) % 2));
`endif
    endtask

    // Advance one rising edge, update the model from the sampled inputs, then check.
    task automatic cycle(input string ph);
        logic [7:0] w8 [4];
        logic       w1 [4];
        int         idx;
        @(posedge clk);
        w8  = '{a8, b8, c8, d8};
        w1  = '{a1, b1, c1, d1};
        idx = 2 * int'(s1) + int'(s0);
        if (!rst_n) begin
            model_clear();
        end else if (in_valid) begin
            m_y1  = w1[idx];
            m_y8  = w8[idx];
            m_sel = 2'(idx);
            m_v   = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        #1 check_outputs(ph);
    endtask

    task automatic randomize_inputs();
        {a1, b1, c1, d1} = 4'($urandom);
        a8 = 8'($urandom); b8 = 8'($urandom);
        c8 = 8'($urandom); d8 = 8'($urandom);
        {s1, s0} = 2'($urandom);
    endtask

    logic [6:0] sweep [8];

    initial begin
        // rows: {a,b,c,d,s0,s1,y}
        sweep[0] = 7'b1000_00_1;
        sweep[1] = 7'b0111_00_0;
        sweep[2] = 7'b0100_10_1;
        sweep[3] = 7'b1011_10_0;
        sweep[4] = 7'b0010_01_1;
        sweep[5] = 7'b1110_01_1;
        sweep[6] = 7'b0001_11_1;
        sweep[7] = 7'b1110_11_0;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        randomize_inputs();
        model_clear();
        #1 check_outputs("rst0");

        // Reset held while inputs toggle
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            randomize_inputs();
            in_valid = 1'b1;
            cycle("rst_hold");
        end

        // Release mid-cycle, then first capture
        @(negedge clk);
        #2 rst_n = 1'b1;
        {a1, b1, c1, d1} = 4'b1000;
        a8 = 8'h01;
        {s1, s0} = 2'b00;
        in_valid = 1'b1;
        cycle("first");
        check("first.y1_one", 64'(y1), 64'd1);

        // Select sweep on WIDTH=1
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, c1, d1} = sweep[i][6:3];
            s0 = sweep[i][2];
            s1 = sweep[i][1];
            in_valid = 1'b1;
            cycle("sweep");
            check("sweep.y_tbl", 64'(y1), 64'(sweep[i][0]));
            check("sweep.sel_tbl", 64'(sel1_q), 64'({sweep[i][1], sweep[i][2]}));
        end

        // Hold: capture b=1 on select 01, then idle with flipped inputs
        @(negedge clk);
        {a1, b1, c1, d1} = 4'b0100;
        {s1, s0} = 2'b01;
        in_valid = 1'b1;
        cycle("hold_cap");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            {a1, b1, c1, d1} = ~{a1, b1, c1, d1};
            {s1, s0} = ~{s1, s0};
            cycle("hold");
            check("hold.y", 64'(y1), 64'd1);
            check("hold.sel", 64'(sel1_q), 64'd1);
            check("hold.vld", 64'(y1_valid), 64'd0);
        end

        // Isolation on WIDTH=8
        @(negedge clk);
        a8 = 8'hA5; b8 = 8'h3C; c8 = 8'hFF; d8 = 8'h00;
        {s1, s0} = 2'b10;
        in_valid = 1'b1;
        cycle("iso");
        check("iso.y", 64'(y8), 64'hFF);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; d8 = 8'h56;
        cycle("iso2");
        check("iso2.y", 64'(y8), 64'hFF);

`ifdef MUX_4X1_PARITY_EN
        // Parity spot checks
        @(negedge clk);
        a8 = 8'h07; {s1, s0} = 2'b00; in_valid = 1'b1;
        cycle("par07");
        check("par07.bit", 64'(y8_par), 64'd1);
        @(negedge clk);
        a8 = 8'h03;
        cycle("par03");
        check("par03.bit", 64'(y8_par), 64'd0);
`endif

        // Mid-stream reset between edges 2 and 3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            randomize_inputs();
            in_valid = 1'b1;
            cycle("stream");
            if (i == 1) begin
                #1 rst_n = 1'b0;
                model_clear();
                #1 check_outputs("mid_rst");
                rst_n = 1'b1;
                #1 check_outputs("post_rst");
                check("post_rst.vld", 64'(y8_valid), 64'd0);
            end
        end

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            randomize_inputs();
            in_valid = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
